play_sequencer: RTL and testbench
=================================

// Module: play_sequencer
// PURPOSE
//  Top-level playback controller for the music player. Converts one-cycle button
//  pulses (play/pause, next) and the reader's song_done into the play level, song
//  index and a one-cycle rewind pulse for the song reader / note player. Supports
//  auto-advance to the next song after a silent gap, with wrap-around at the last song.
// PARAMETERS
//  NUM_SONGS   4      number of songs in ROM, 1..4; index wraps NUM_SONGS-1 -> 0
//  GAP_CYCLES  48000  silent cycles between songs in auto-advance, >=1
// PORTS
//  clk          in   1  system clock
//  reset        in   1  synchronous, active-high reset
//  play_pause   in   1  one-cycle pulse (debounced upstream); toggles play/pause
//  next         in   1  one-cycle pulse; skip to next song
//  auto_next    in   1  level; 1 = advance after song_done, 0 = stop and rewind
//  song_done    in   1  from song reader; current song finished
//  play         out  1  to song reader; 1 = playback requested
//  song         out  2  current song index, registered
//  reset_play   out  1  one-cycle rewind pulse to song reader / note player
// BEHAVIOUR
//  States: S_RESET, S_PAUSE, S_PLAY, S_GAP, S_NEXT. play=1 only in S_PLAY;
//   reset_play=1 only in S_RESET and S_NEXT (Moore decode of registered state).
//  Reset: state<=S_RESET, song<=0, gap count<=0, resume<=0. play=0, reset_play=1
//   while reset high and for exactly one cycle after release.
//  Latency: input sampled at edge n -> new state/outputs valid after edge n.
//  S_RESET: -> S_PAUSE unconditionally (song unchanged).
//  S_PAUSE: next -> S_NEXT, resume<=0; else play_pause -> S_PLAY. next wins if both.
//   song_done ignored.
//  S_PLAY priority song_done > next > play_pause:
//   song_done & auto_next -> S_GAP, gap count<=0;
//   song_done & !auto_next -> S_RESET (rewind, stop, song unchanged);
//   next -> S_NEXT, resume<=1; play_pause -> S_PAUSE.
//  S_GAP: count increments each cycle; at count==GAP_CYCLES-1 -> S_NEXT, resume<=1.
//   next -> S_NEXT immediately, resume<=1. play_pause -> S_NEXT, resume<=0 (advance,
//   stay paused). next wins over play_pause; both win over timeout.
//  S_NEXT: song<=(song==NUM_SONGS-1)?0:song+1 on exit edge; -> S_PLAY if resume else
//   S_PAUSE. Inputs ignored in this state. reset_play high for this one cycle,
//   song shows the OLD index during it, new index from following cycle.
//  Gap counter width $clog2(GAP_CYCLES+1); held at 0 outside S_GAP; no overflow.
//  Reset mid-operation (any state, incl. S_GAP/S_NEXT) takes priority over all inputs.
//  NUM_SONGS=1: next/auto-advance replay song 0 with a rewind pulse.
//  Illegal state encoding -> S_RESET next cycle.
// TESTING (bench uses GAP_CYCLES=4, NUM_SONGS=4)
//  1 reset 2 cycles, release -> song=0, play=0, reset_play=1 for 1 cycle after release, then 0.
//  2 in PAUSE, play_pause pulse -> play=1 next cycle; second pulse -> play=0; song=0 throughout.
//  3 PLAY song=3, next pulse -> 1 cycle reset_play=1 (song=3), then song=0, play=1.
//  4 PLAY song=0, auto_next=1, song_done -> play=0 exactly 4 cycles, 1 cycle reset_play, song=1, play=1.
//  5 PLAY song=2, auto_next=0, song_done -> 1 cycle reset_play, then PAUSE: play=0, song=2.
//  6 PLAY: song_done+next+play_pause same cycle -> gap path taken; reset during gap -> song=0, play=0.

Source files
------------

// File: rtl/play_sequencer.sv
// play_sequencer
//   Top-level playback controller. Turns one-cycle button pulses (play_pause,
//   next) and the song reader's song_done into a play level, a registered song
//   index and a one-cycle rewind pulse. With auto_next set, a finished song is
//   followed by a silent gap of GAP_CYCLES cycles and then the next song, with
//   the index wrapping from the last song back to song 0.
//
// Parameters
//   NUM_SONGS   songs held in ROM (1..4); index wraps NUM_SONGS-1 -> 0
//   GAP_CYCLES  silent cycles between songs when auto-advancing (>=1)
//
// Ports
//   clk         system clock
//   reset       synchronous, active-high reset
//   play_pause  one-cycle pulse, toggles play/pause
//   next        one-cycle pulse, skip to the next song
//   auto_next   level: 1 = advance after song_done, 0 = stop and rewind
//   song_done   current song has finished (from song reader)
//   play        playback requested (high only while playing)
//   song        current song index, registered
//   reset_play  one-cycle rewind pulse to song reader / note player
//
// All outputs are a Moore decode of the registered state, so an input sampled
// on edge n is reflected on the outputs right after edge n.

module play_sequencer #(
  parameter int NUM_SONGS  = 4,
  parameter int GAP_CYCLES = 48000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       play_pause,
  input  logic       next,
  input  logic       auto_next,
  input  logic       song_done,
  output logic       play,
  output logic [1:0] song,
  output logic       reset_play
);

  localparam int CW = $clog2(GAP_CYCLES + 1);

  // Last valid gap count and last valid song index, pre-sized to the
  // registers they are compared against.
  localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_CYCLES - 1);
  localparam logic [1:0]    SONG_LAST = 2'(NUM_SONGS - 1);

  typedef enum logic [2:0] {
    S_RESET = 3'd0,
    S_PAUSE = 3'd1,
    S_PLAY  = 3'd2,
    S_GAP   = 3'd3,
    S_NEXT  = 3'd4
  } state_t;

  // Complete sequencer state. resume records whether the song entered via
  // S_NEXT should start playing (1) or wait paused (0).
  typedef struct packed {
    state_t        st;
    logic [1:0]    song;
    logic [CW-1:0] cnt;
    logic          resume;
  } seq_t;

  seq_t seq_q, seq_d;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      seq_q.st     <= S_RESET;
      seq_q.song   <= 2'd0;
      seq_q.cnt    <= '0;
      seq_q.resume <= 1'b0;
    end else begin
      seq_q <= seq_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // Hold by default; the gap counter is forced to 0 everywhere except
    // while counting inside S_GAP.
    seq_d     = seq_q;
    seq_d.cnt = '0;

    unique case (seq_q.st)
      S_RESET: begin
        seq_d.st = S_PAUSE;
      end

      S_PAUSE: begin
        // song_done is meaningless while paused and is ignored.
        if (next) begin
          seq_d.st     = S_NEXT;
          seq_d.resume = 1'b0;
        end else if (play_pause) begin
          seq_d.st = S_PLAY;
        end
      end

      S_PLAY: begin
        // A finishing song outranks the buttons pressed in the same cycle.
        if (song_done) begin
          seq_d.st = auto_next ? S_GAP : S_RESET;
        end else if (next) begin
          seq_d.st     = S_NEXT;
          seq_d.resume = 1'b1;
        end else if (play_pause) begin
          seq_d.st = S_PAUSE;
        end
      end

      S_GAP: begin
        // Buttons cut the gap short; play_pause still advances the song but
        // leaves the player paused on it.
        if (next) begin
          seq_d.st     = S_NEXT;
          seq_d.resume = 1'b1;
        end else if (play_pause) begin
          seq_d.st     = S_NEXT;
          seq_d.resume = 1'b0;
        end else if (seq_q.cnt == GAP_LAST) begin
          seq_d.st     = S_NEXT;
          seq_d.resume = 1'b1;
        end else begin
          seq_d.cnt = seq_q.cnt + CW'(1);
        end
      end

      S_NEXT: begin
        // The old index stays visible during the rewind pulse; the new one
        // appears on the exit edge. With one song this replays song 0.
        seq_d.song = (seq_q.song == SONG_LAST) ? 2'd0 : seq_q.song + 2'd1;
        seq_d.st   = seq_q.resume ? S_PLAY : S_PAUSE;
      end

      default: begin
        // Unreachable encodings recover through a clean rewind.
        seq_d.st = S_RESET;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Moore outputs
  // ---------------------------------------------------------------------------
  assign play       = (seq_q.st == S_PLAY);
  assign reset_play = (seq_q.st == S_RESET) || (seq_q.st == S_NEXT);
  assign song       = seq_q.song;

endmodule

// File: tb/tb_play_sequencer.sv
// Self-checking bench for play_sequencer (GAP_CYCLES=4, NUM_SONGS=4).
// Each step drives one cycle of inputs, pushes the expected outputs onto a
// scoreboard queue, and after the clock edge pops and compares them.
// Expected values are hand-derived from the behavioural description.

module tb_play_sequencer;

  logic       clk = 1'b0;
  logic       reset, play_pause, next, auto_next, song_done;
  logic       play, reset_play;
  logic [1:0] song;

  play_sequencer #(.NUM_SONGS(4), .GAP_CYCLES(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .play_pause (play_pause),
    .next       (next),
    .auto_next  (auto_next),
    .song_done  (song_done),
    .play       (play),
    .song       (song),
    .reset_play (reset_play)
  );

  always #5 clk = ~clk;

  // in  = {reset, play_pause, next, auto_next, song_done}
  // out = {play, song[1:0], reset_play}
  typedef struct {
    logic [4:0] in;
    logic [3:0] out;
  } vec_t;

  typedef struct {
    logic [3:0] out;
    int         id;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   step_id = 0;

  task automatic cmp(input string nm, input int id, input logic [3:0] act, input logic [3:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s step %0d: got play=%b song=%0d reset_play=%b, want play=%b song=%0d reset_play=%b",
               nm, id, act[3], act[2:1], act[0], req[3], req[2:1], req[0]);
    end
  endtask

  task automatic step(input logic [4:0] in, input logic [3:0] out);
    exp_t e;
    {reset, play_pause, next, auto_next, song_done} = in;
    sb.push_back('{out, step_id});
    step_id++;
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard step %0d: queue empty", step_id);
    end else begin
      e = sb.pop_front();
      cmp("outputs", e.id, {play, song, reset_play}, e.out);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; play_pause = 1'b0; next = 1'b0; auto_next = 1'b0; song_done = 1'b0;

    // Reset held two cycles.
    tbl.push_back('{5'b10000, 4'b0001});
    tbl.push_back('{5'b10000, 4'b0001});
    foreach (tbl[i]) step(tbl[i].in, tbl[i].out);
    tbl.delete();

    // Rewind pulse still high in the cycle following release.
    {reset, play_pause, next, auto_next, song_done} = 5'b00000;
    #1;
    cmp("release_rewind", -1, {play, song, reset_play}, 4'b0001);

    // Pause / play, skipping, wrap-around and stop-on-done.
    tbl.push_back('{5'b00000, 4'b0000}); // RESET -> PAUSE
    tbl.push_back('{5'b00000, 4'b0000});
    tbl.push_back('{5'b01000, 4'b1000}); // play_pause -> PLAY
    tbl.push_back('{5'b00000, 4'b1000});
    tbl.push_back('{5'b01000, 4'b0000}); // play_pause -> PAUSE
    tbl.push_back('{5'b00001, 4'b0000}); // song_done ignored in PAUSE
    tbl.push_back('{5'b00100, 4'b0001}); // next in PAUSE -> NEXT, old song
    tbl.push_back('{5'b00000, 4'b0010}); // PAUSE, song 1
    tbl.push_back('{5'b01000, 4'b1010}); // PLAY song 1
    tbl.push_back('{5'b00100, 4'b0011}); // NEXT
    tbl.push_back('{5'b00000, 4'b1100}); // PLAY song 2
    tbl.push_back('{5'b00100, 4'b0101}); // NEXT
    tbl.push_back('{5'b00000, 4'b1110}); // PLAY song 3
    tbl.push_back('{5'b00100, 4'b0111}); // next on last song: rewind, song 3
    tbl.push_back('{5'b00000, 4'b1000}); // wrapped to song 0, playing
    tbl.push_back('{5'b00100, 4'b0001});
    tbl.push_back('{5'b00000, 4'b1010}); // PLAY song 1
    tbl.push_back('{5'b00100, 4'b0011});
    tbl.push_back('{5'b00000, 4'b1100}); // PLAY song 2
    tbl.push_back('{5'b00001, 4'b0101}); // done, auto_next=0 -> RESET
    tbl.push_back('{5'b00000, 4'b0100}); // PAUSE, song 2 kept
    tbl.push_back('{5'b00000, 4'b0100});
    tbl.push_back('{5'b01100, 4'b0101}); // next beats play_pause in PAUSE
    tbl.push_back('{5'b00000, 4'b0110}); // PAUSE song 3 (resume=0)
    tbl.push_back('{5'b01000, 4'b1110}); // PLAY song 3
    tbl.push_back('{5'b01100, 4'b0111}); // next beats play_pause in PLAY
    tbl.push_back('{5'b00000, 4'b1000}); // PLAY song 0
    foreach (tbl[i]) step(tbl[i].in, tbl[i].out);

    // Auto-advance: exactly four silent cycles, one rewind, then song 1.
    step(5'b00011, 4'b0000); // GAP cnt 0
    step(5'b00010, 4'b0000); // cnt 1
    step(5'b00010, 4'b0000); // cnt 2
    step(5'b00010, 4'b0000); // cnt 3
    step(5'b00010, 4'b0001); // timeout -> NEXT
    step(5'b00010, 4'b1010); // PLAY song 1

    // next cuts the gap short and keeps playing.
    step(5'b00011, 4'b0010);
    step(5'b00110, 4'b0011);
    step(5'b00010, 4'b1100); // PLAY song 2

    // play_pause in the gap advances but stays paused.
    step(5'b00011, 4'b0100);
    step(5'b01010, 4'b0101);
    step(5'b00010, 4'b0110); // PAUSE song 3
    step(5'b01010, 4'b1110); // PLAY song 3

    // next + play_pause in the gap: next wins, wraps and plays.
    step(5'b00011, 4'b0110);
    step(5'b01110, 4'b0111);
    step(5'b00010, 4'b1000); // PLAY song 0

    // All three events at once in PLAY take the gap path; reset in the gap.
    step(5'b00110, 4'b0001);
    step(5'b00010, 4'b1010); // PLAY song 1
    step(5'b01111, 4'b0010); // GAP, not NEXT
    step(5'b00010, 4'b0010); // still GAP
    step(5'b11110, 4'b0001); // reset beats inputs: RESET song 0
    step(5'b00000, 4'b0000); // PAUSE song 0

    // Reset during the rewind cycle: song must not advance.
    step(5'b01000, 4'b1000); // PLAY song 0
    step(5'b00100, 4'b0001); // NEXT
    step(5'b10000, 4'b0001); // reset in NEXT
    step(5'b00000, 4'b0000); // PAUSE song 0

    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_drain: %0d left, want 0", sb.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
